data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH_WORDS SHALL default to 1024 and set storage size in 32-bit words; it must be a power of two.
REQ-002 Parameter WAIT_CYCLES SHALL default to 2 and set the wait states between request acceptance and response; legal range is 0..15.
REQ-003 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  request present from the memory pipeline stage.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-008 req_address  input  32  byte address, little-endian.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 resp_valid  output  1  one-cycle response strobe.
REQ-012 resp_rdata  output  32  load data, right-aligned and zero-extended; sign extension belongs to the pipeline.
REQ-013 resp_error  output  1  the access was rejected, qualified by resp_valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESPOND.
REQ-015 req_ready SHALL equal (state == IDLE) combinationally; all other outputs SHALL be registered.
REQ-016 A request SHALL be accepted on the edge where req_valid && req_ready; req_we, req_size, req_address and req_wdata SHALL be latched at that edge, and later input changes SHALL be ignored.
REQ-017 On acceptance the FSM SHALL go IDLE -> WAIT with wait counter = WAIT_CYCLES-1, or IDLE -> RESPOND when WAIT_CYCLES = 0.
REQ-018 In WAIT the counter SHALL decrement each edge; at counter == 0 the next state SHALL be RESPOND.
REQ-019 RESPOND SHALL last exactly one cycle and then return to IDLE; req_valid is ignored outside IDLE, so back-to-back accepts are spaced WAIT_CYCLES+2 cycles apart.
REQ-020 resp_valid SHALL be 1 exactly during the RESPOND cycle, i.e. cycle A+WAIT_CYCLES+1 where A is the accept edge.
REQ-021 The error condition SHALL be: req_size == 11; or half with addr[0] != 0; or word with addr[1:0] != 0; or addr[31:2] >= DEPTH_WORDS.
REQ-022 On error resp_error SHALL be 1, resp_rdata SHALL be 0, and storage SHALL NOT be modified.
REQ-023 A legal store SHALL write only the addressed byte lanes: byte lane addr[1:0], half lanes {addr[1],0} and {addr[1],1}, word all four; the write SHALL be committed on the edge entering RESPOND.
REQ-024 For a store, resp_rdata SHALL be 0 and resp_error SHALL be 0.
REQ-025 A legal load SHALL register the selected lanes, zero-extended, on the edge entering RESPOND.
REQ-026 A load issued after a completed store to the same address SHALL return the stored data.
REQ-027 Storage contents SHALL NOT be reset and are undefined until written; the verification bench must write before reading.

Reset
REQ-028 While reset is asserted: state = IDLE, counter = 0, resp_valid = 0, resp_rdata = 0, resp_error = 0, latched request = 0, and req_ready = 1 once reset is released.
REQ-029 Reset asserted in WAIT or RESPOND SHALL abort the transaction with no response; a store aborted before its RESPOND-entry edge SHALL leave storage unchanged.
REQ-030 The first request SHALL be accepted on the first rising edge after reset deasserts with req_valid = 1.

Verification (WAIT_CYCLES = 2, DEPTH_WORDS = 1024)
REQ-031 Word store 0xDEADBEEF @0x10, then word load @0x10 -> resp_valid 3 cycles after each accept, rdata 0xDEADBEEF, error 0.
REQ-032 Byte store 0x80 @0x13, then word load @0x10 and byte load @0x13 -> word load returns 0x80ADBEEF; byte load returns 0x00000080 (zero-extended).
REQ-033 Half load @0x11; word load @0x12; size = 11 @0x0; word load @0x1000 -> each gives resp_error = 1 and rdata 0, and a follow-up load @0x10 shows storage unchanged.
REQ-034 Hold req_valid high continuously for 3 requests -> req_ready low in WAIT/RESPOND, accepts exactly 4 cycles apart, exactly 3 resp_valid pulses each 1 cycle wide, and input changes after an accept do not affect that accept's response.
REQ-035 Word store 0x12345678 @0x20 with reset pulsed in the WAIT cycle after the accept -> no resp_valid, all outputs 0, and a later load @0x20 returns the pre-store contents.
REQ-036 Rebuild with WAIT_CYCLES = 0; word load @0x10 -> resp_valid in the cycle right after the accept edge, and req_ready high again the following cycle.

Source files
------------

// File: rtl/data_memory_responder.sv
// Word-organised data memory with a fixed-latency request/response handshake.
// One request in flight at a time; sub-word accesses use little-endian byte lanes.
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_error_q;

  logic [31:0] mem [DEPTH_WORDS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = RESPOND;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESPOND;
        else             cnt_d   = cnt_q - 4'd1;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);

  // With zero wait states RESPOND is entered on the accept edge itself, so the
  // request being serviced comes straight from the ports while in IDLE.
  logic        cur_we;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr, cur_wdata;
  assign cur_we    = req_ready ? req_we      : we_q;
  assign cur_size  = req_ready ? req_size    : size_q;
  assign cur_addr  = req_ready ? req_address : addr_q;
  assign cur_wdata = req_ready ? req_wdata   : wdata_q;

  logic          cur_err;
  logic          enter_resp;
  logic          mem_we;
  logic [AW-1:0] widx;
  logic [31:0]   word, shifted, load_data, wlanes;
  logic [3:0]    be;

  assign cur_err = (cur_size == 2'b11)
                || (cur_size == 2'b01 && cur_addr[0])
                || (cur_size == 2'b10 && cur_addr[1:0] != 2'b00)
                || ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS);

  assign enter_resp = (state_d == RESPOND);
  assign mem_we     = enter_resp && cur_we && !cur_err && !reset;
  assign widx       = cur_addr[AW+1:2];
  assign word       = mem[widx];
  assign shifted    = word >> {cur_addr[1:0], 3'b000};

  always_comb begin
    load_data = '0;
    be        = '0;
    wlanes    = cur_wdata;
    unique case (cur_size)
      2'b00: begin
        load_data = {24'h0, shifted[7:0]};
        be[cur_addr[1:0]] = 1'b1;
        wlanes = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        load_data = {16'h0, shifted[15:0]};
        be = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{cur_wdata[15:0]}};
      end
      2'b10: begin
        load_data = word;
        be = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        addr_q  <= req_address;
        wdata_q <= req_wdata;
      end
      resp_valid_q <= enter_resp;
      resp_rdata_q <= (enter_resp && !cur_we && !cur_err) ? load_data : '0;
      resp_error_q <= enter_resp && cur_err;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: byte-addressed reference model, directed
// scenarios, randomized traffic, and a zero-wait-state instance.
`timescale 1ns/1ps
module tb_data_memory_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAITC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [1:0]  req_size;
  logic [31:0] req_address, req_wdata;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata;

  logic        z_valid, z_we;
  logic [1:0]  z_size;
  logic [31:0] z_address, z_wdata;
  logic        z_ready, z_resp_valid, z_resp_error;
  logic [31:0] z_resp_rdata;

  int ncmp = 0;
  int nfail = 0;
  int pulses = 0;
  time last_acc;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_address(req_address), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error));

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_valid), .req_we(z_we),
    .req_size(z_size), .req_address(z_address), .req_wdata(z_wdata),
    .req_ready(z_ready), .resp_valid(z_resp_valid), .resp_rdata(z_resp_rdata),
    .resp_error(z_resp_error));

  always @(negedge clk) if (resp_valid === 1'b1) pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: byte-addressed store, rules applied arithmetically.
  byte unsigned ref_mem [int unsigned];

  function automatic bit ref_err(input bit [1:0] sz, input bit [31:0] a);
    int unsigned nb;
    if (sz == 2'd3) return 1'b1;
    nb = 1 << sz;
    return ((a % nb) != 0) || ((a / 4) >= DEPTH);
  endfunction

  function automatic logic [31:0] ref_load(input bit [1:0] sz, input bit [31:0] a);
    logic [31:0] v = '0;
    for (int unsigned i = 0; i < (1 << sz); i++) v |= 32'(ref_mem[a + i]) << (8 * i);
    return v;
  endfunction

  task automatic ref_store(input bit [1:0] sz, input bit [31:0] a, input bit [31:0] wd);
    for (int unsigned i = 0; i < (1 << sz); i++) ref_mem[a + i] = 8'(wd >> (8 * i));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    ncmp++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic scramble(input bit hold);
    req_we      = 1'($urandom);
    req_size    = 2'($urandom);
    req_address = $urandom;
    req_wdata   = $urandom;
    req_valid   = hold ? 1'b1 : 1'($urandom);
  endtask

  // One transaction on the WAIT_CYCLES=2 instance, starting and ending at a negedge in IDLE.
  task automatic xact(input bit we, input bit [1:0] sz, input bit [31:0] a,
                      input bit [31:0] wd, input bit hold, output logic [31:0] rd);
    bit e;
    logic [31:0] exp_rd;
    int lat;
    e = ref_err(sz, a);
    exp_rd = (we || e) ? 32'h0 : ref_load(sz, a);
    req_valid = 1'b1; req_we = we; req_size = sz; req_address = a; req_wdata = wd;
    chk("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    last_acc = $time;
    @(negedge clk);
    scramble(hold);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      chk("ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      scramble(hold);
      lat++;
    end
    chk("latency", 32'(lat), 32'(WAITC + 1));
    chk("ready_resp", 32'(req_ready), 32'd0);
    chk("rdata", resp_rdata, exp_rd);
    chk("error", 32'(resp_error), 32'(e));
    rd = resp_rdata;
    if (we && !e) ref_store(sz, a, wd);
    @(negedge clk);
    chk("pulse_width", 32'(resp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic xact0(input bit we, input bit [1:0] sz, input bit [31:0] a,
                       input bit [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
    z_valid = 1'b1; z_we = we; z_size = sz; z_address = a; z_wdata = wd;
    chk("z_ready_idle", 32'(z_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    z_valid = 1'b0; z_wdata = $urandom; z_address = $urandom;
    chk("z_resp_next_cycle", 32'(z_resp_valid), 32'd1);
    chk("z_ready_resp", 32'(z_ready), 32'd0);
    chk("z_rdata", z_resp_rdata, exp_rd);
    chk("z_error", 32'(z_resp_error), 32'(exp_err));
    @(negedge clk);
    chk("z_pulse_width", 32'(z_resp_valid), 32'd0);
    chk("z_ready_back", 32'(z_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd, pre;
    time t0;
    int p0;
    bit we;
    bit [1:0] sz;
    bit [31:0] a;

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_address = '0; req_wdata = '0;
    z_valid = 1'b0; z_we = 1'b0; z_size = '0; z_address = '0; z_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_error", 32'(resp_error), 32'd0);
    reset = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);

    // Fill words 0x00..0xFF so every later load reads defined storage.
    for (int unsigned w = 0; w < 64; w++) xact(1'b1, 2'd2, 32'(w * 4), $urandom, 1'b0, rd);

    xact(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, rd);
    xact(1'b0, 2'd2, 32'h10, 32'h0, 1'b0, rd);
    chk("word_load", rd, 32'hDEADBEEF);

    xact(1'b1, 2'd0, 32'h13, 32'h0000_0080, 1'b0, rd);
    xact(1'b0, 2'd2, 32'h10, 32'h0, 1'b0, rd);
    chk("byte_merge", rd, 32'h80ADBEEF);
    xact(1'b0, 2'd0, 32'h13, 32'h0, 1'b0, rd);
    chk("byte_zext", rd, 32'h0000_0080);

    xact(1'b0, 2'd1, 32'h11, 32'h0, 1'b0, rd);
    xact(1'b0, 2'd2, 32'h12, 32'h0, 1'b0, rd);
    xact(1'b0, 2'd3, 32'h0, 32'h0, 1'b0, rd);
    xact(1'b0, 2'd2, 32'h1000, 32'h0, 1'b0, rd);
    xact(1'b1, 2'd2, 32'h12, 32'h11111111, 1'b0, rd);
    xact(1'b1, 2'd2, 32'h1000, 32'h22222222, 1'b0, rd);
    xact(1'b0, 2'd2, 32'h10, 32'h0, 1'b0, rd);
    chk("err_no_write", rd, 32'h80ADBEEF);

    // Reset pulsed in the WAIT cycle of a store must drop it without a trace.
    pre = ref_load(2'd2, 32'h20);
    p0 = pulses;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_address = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_error", 32'(resp_error), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_pulse", 32'(pulses - p0), 32'd0);
    xact(1'b0, 2'd2, 32'h20, 32'h0, 1'b0, rd);
    chk("abort_storage", rd, pre);

    // Three requests with req_valid held high the whole time.
    p0 = pulses;
    xact(1'b1, 2'd1, 32'h42, 32'hAAAA_5A5A, 1'b1, rd);
    t0 = last_acc;
    xact(1'b0, 2'd2, 32'h40, 32'h0, 1'b1, rd);
    chk("hold_spacing1", 32'(last_acc - t0), 32'd40);
    t0 = last_acc;
    xact(1'b0, 2'd0, 32'h43, 32'h0, 1'b1, rd);
    chk("hold_spacing2", 32'(last_acc - t0), 32'd40);
    req_valid = 1'b0;
    chk("hold_pulses", 32'(pulses - p0), 32'd3);

    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       a = 32'h1000 + 32'($urandom_range(0, 255));
        1:       a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(0, 255));
      endcase
      xact(we, sz, a, $urandom, 1'b0, rd);
    end

    xact0(1'b1, 2'd2, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
    xact0(1'b0, 2'd2, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
    xact0(1'b1, 2'd0, 32'h11, 32'h5A, 32'h0, 1'b0);
    xact0(1'b0, 2'd1, 32'h10, 32'h0, 32'h0000_5A0D, 1'b0);
    xact0(1'b0, 2'd2, 32'h2, 32'h0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
